// File: rtl/clk_ctrl_pkg.sv
// Shared types and defaults for the programmable clock divider controller.
package clk_ctrl_pkg;
  localparam int CNT_W_DEF   = 25;
  localparam int DEF_DIV_DEF = 8333333;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;
endpackage

// File: rtl/clk_div_core.sv
// Counter/toggle datapath: counts to term, then toggles out_clk and pulses tick.
module clk_div_core import clk_ctrl_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             inp_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] term,
  output logic             out_clk,
  output logic             tick,
  output logic             wrap
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;

  // clr dominates so a clean stop never produces a last-cycle toggle
  assign wrap = en && !clr && (cnt_q == term);

  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      out_d  = ~out_q;
      tick_d = 1'b1;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge inp_clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign out_clk = out_q;
  assign tick    = tick_q;
endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: run/stop FSM plus glitch-free divisor reconfiguration.
module clk_div_ctrl import clk_ctrl_pkg::*; #(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             inp_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             out_clk,
  output logic             tick,
  output logic             busy
);
  state_e           state_q, state_d;
  logic             en, clr, wrap, accept;
  logic [CNT_W-1:0] div_q, div_d, shadow_q, shadow_d;
  logic             pend_q, pend_d;

  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .inp_clk (inp_clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .term    (div_q),
    .out_clk (out_clk),
    .tick    (tick),
    .wrap    (wrap)
  );

  always_ff @(posedge inp_clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (start && !stop) state_d = ST_RUN;
      // a stop that lands on the falling terminal count finishes right away
      ST_RUN:      if (stop) state_d = (out_clk && !wrap) ? ST_STOPPING : ST_IDLE;
      ST_STOPPING: if (start && !stop) state_d = ST_RUN;
                   else if (wrap)      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    en   = 1'b0;
    clr  = 1'b0;
    busy = 1'b0;
    unique case (state_q)
      ST_IDLE:     clr = start && !stop;
      ST_RUN:      begin en = 1'b1; busy = 1'b1; clr = stop && !out_clk; end
      ST_STOPPING: begin en = 1'b1; busy = 1'b1; end
      default:     ;
    endcase
  end

  assign cfg_ready = !pend_q;
  assign accept    = cfg_valid && cfg_ready;

  // divisor only swaps on a terminal count or when the counter goes quiet
  always_comb begin
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (pend_q && (wrap || state_d == ST_IDLE)) begin
      div_d  = shadow_q;
      pend_d = 1'b0;
    end
    if (accept) begin
      if (state_q == ST_IDLE || state_d == ST_IDLE) begin
        div_d = cfg_div;
      end else begin
        shadow_d = cfg_div;
        pend_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge inp_clk or posedge rst) begin
    if (rst) begin
      div_q    <= CNT_W'(DEF_DIV);
      shadow_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
    end
  end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl with a countdown-based reference model.
module tb_clk_div_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, stop, cfg_valid;
  logic [3:0] cfg_div;
  logic       cfg_ready, out_clk, tick, busy;

  clk_div_ctrl #(.CNT_W(4), .DEF_DIV(3)) dut (
    .inp_clk   (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .out_clk   (out_clk),
    .tick      (tick),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] sb_q[$];
  logic [3:0] exp_v, act_v;

  // reference model: mode 0 idle, 1 run, 2 stopping; m_left = edges until next toggle
  int m_mode, m_left, m_div, m_shadow;
  bit m_out, m_tick, m_pend, m_acc;
  bit cv_h;
  logic [3:0] cd_h;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_div = 3; m_shadow = 0;
    m_out = 0; m_tick = 0; m_pend = 0; m_acc = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit cv, input logic [3:0] cd);
    bit due, tog;
    int nmode;
    m_acc = cv && !m_pend;
    due   = (m_mode != 0) && (m_left == 1);
    tog   = 0;
    nmode = m_mode;
    case (m_mode)
      0: if (st && !sp) nmode = 1;
      1: if (sp) begin
           if (m_out) begin tog = due; nmode = due ? 0 : 2; end
           else nmode = 0;
         end else tog = due;
      default: begin
        tog = due;
        if (st && !sp) nmode = 1;
        else if (due)  nmode = 0;
      end
    endcase
    if (m_pend && (tog || nmode == 0)) begin m_div = m_shadow; m_pend = 0; end
    if (m_acc) begin
      if (m_mode == 0 || nmode == 0) m_div = int'(cd);
      else begin m_shadow = int'(cd); m_pend = 1; end
    end
    m_tick = tog;
    if (tog) m_out = !m_out;
    if (nmode != 0) begin
      if (m_mode == 0 || tog) m_left = m_div + 1;
      else                    m_left = m_left - 1;
    end
    m_mode = nmode;
  endtask

  // one clock: apply inputs, model the edge, queue expected post-edge outputs
  task automatic drive_cycle(input bit st, input bit sp, input bit cv, input logic [3:0] cd);
    start = st; stop = sp; cfg_valid = cv; cfg_div = cd;
    @(posedge clk);
    model_step(st, sp, cv, cd);
    sb_q.push_back({m_out, m_tick, m_mode != 0, !m_pend});
    @(negedge clk);
    start = 0; stop = 0; cfg_valid = 0;
  endtask

  task automatic rnd_cycle(input bit st, input bit sp);
    drive_cycle(st, sp, cv_h, cd_h);
    if (m_acc) cv_h = 0;
  endtask

  task automatic go_idle();
    int k;
    k = 0;
    while ((m_mode != 0 || cv_h) && k < 60) begin
      rnd_cycle(0, 1);
      k++;
    end
    chk("reach_idle", (m_mode == 0 && !cv_h) ? 1 : 0, 1);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_v = sb_q.pop_front();
      act_v = {out_clk, tick, busy, cfg_ready};
      n_checks++;
      if (act_v !== exp_v) begin
        n_errors++;
        $display("FAIL scoreboard out/tick/busy/ready at %0t: got %b expected %b", $time, act_v, exp_v);
      end
    end
  end

  initial begin
    int rise_k, fall_k, ticks;
    rst = 1; start = 0; stop = 0; cfg_valid = 0; cfg_div = '0;
    cv_h = 0; cd_h = '0;
    model_reset();
    #12;
    chk("rst_out_clk", out_clk, 0);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    @(negedge clk); rst = 0;

    // default divisor: rise at cycle 5, fall at cycle 9, then stop on the terminal count
    rise_k = -1; fall_k = -1;
    drive_cycle(1, 0, 0, 4'd0);
    chk("busy_after_start", busy, 1);
    for (int k = 2; k <= 16; k++) begin
      drive_cycle(0, 0, 0, 4'd0);
      if (out_clk === 1'b1 && rise_k < 0) rise_k = k;
      if (out_clk === 1'b0 && rise_k > 0 && fall_k < 0) fall_k = k;
    end
    chk("first_rise_cycle", rise_k, 5);
    chk("first_fall_cycle", fall_k, 9);
    chk("high_before_stop", out_clk, 1);
    drive_cycle(0, 1, 0, 4'd0);
    chk("stop_on_term_busy", busy, 0);
    chk("stop_on_term_out", out_clk, 0);
    for (int k = 0; k < 3; k++) drive_cycle(0, 0, 0, 4'd0);

    // start and stop together in IDLE
    drive_cycle(1, 1, 0, 4'd0);
    chk("start_stop_idle_busy", busy, 0);

    // reconfigure mid half-period while running
    rnd_cycle(1, 0);
    rnd_cycle(0, 0);
    cv_h = 1; cd_h = 4'd1;
    for (int k = 0; k < 20; k++) rnd_cycle(0, 0);
    go_idle();

    // divisor 0: toggles every cycle with tick held
    cv_h = 1; cd_h = 4'd0;
    rnd_cycle(0, 0);
    rnd_cycle(1, 0);
    ticks = 0;
    for (int k = 0; k < 8; k++) begin
      rnd_cycle(0, 0);
      if (tick === 1'b1) ticks++;
    end
    chk("div0_tick_count", ticks, 8);
    go_idle();
    cv_h = 1; cd_h = 4'd3;
    rnd_cycle(0, 0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if (!cv_h && $urandom_range(15, 0) == 0) begin
        cv_h = 1; cd_h = 4'($urandom_range(5, 0));
      end
      rnd_cycle($urandom_range(19, 0) == 0, $urandom_range(24, 0) == 0);
    end
    go_idle();

    // async reset mid-RUN while out_clk is high must restore the default divisor
    cv_h = 1; cd_h = 4'd5;
    rnd_cycle(0, 0);
    rnd_cycle(1, 0);
    begin
      int k;
      k = 0;
      while (out_clk !== 1'b1 && k < 40) begin drive_cycle(0, 0, 0, 4'd0); k++; end
      chk("wait_out_high", out_clk, 1);
    end
    #2 rst = 1;
    #1;
    chk("async_rst_out", out_clk, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_tick", tick, 0);
    chk("async_rst_ready", cfg_ready, 1);
    @(negedge clk); @(negedge clk);
    rst = 0;
    model_reset(); cv_h = 0;
    for (int k = 0; k < 4; k++) drive_cycle(0, 0, 0, 4'd0);
    rise_k = -1;
    drive_cycle(1, 0, 0, 4'd0);
    for (int k = 2; k <= 8; k++) begin
      drive_cycle(0, 0, 0, 4'd0);
      if (out_clk === 1'b1 && rise_k < 0) rise_k = k;
    end
    chk("post_rst_rise_cycle", rise_k, 5);
    go_idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter CNT_W, default 25: width of divider counter and divisor.
REQ-002 Parameter DEF_DIV, default 8333333: half-period terminal count loaded at reset.
REQ-003 Port inp_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  single-cycle request to begin generating out_clk.
REQ-006 Port stop  input  1  single-cycle request to halt out_clk cleanly at low level.
REQ-007 Port cfg_valid  input  1  new divisor offered on cfg_div.
REQ-008 Port cfg_div  input  CNT_W  requested half-period terminal count.
REQ-009 Port cfg_ready  output  1  controller can accept a divisor this cycle.
REQ-010 Port out_clk  output  1  registered divided clock.
REQ-011 Port tick  output  1  one-cycle pulse coincident with every out_clk toggle.
REQ-012 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM SHALL have states IDLE, RUN, STOPPING; busy = (state != IDLE).
REQ-014 In RUN/STOPPING, counter SHALL increment each cycle; at cnt == active_div, cnt <= 0, out_clk toggles, tick = 1 that cycle.
REQ-015 Out_clk period SHALL be 2*(active_div+1) cycles; first toggle is active_div+1 cycles after the edge entering RUN.
REQ-016 active_div == 0 SHALL toggle out_clk every cycle with tick held high.
REQ-017 IDLE + start SHALL enter RUN next edge with cnt = 0, out_clk = 0.
REQ-018 RUN + stop with out_clk = 0 SHALL go to IDLE next edge, cnt cleared, no toggle.
REQ-019 RUN + stop with out_clk = 1 SHALL go to STOPPING; counting continues; at terminal count out_clk falls and state goes to IDLE.
REQ-020 STOPPING + start (without stop) SHALL return to RUN without disturbing cnt or out_clk.
REQ-021 start and stop in the same cycle: stop SHALL win; start ignored in RUN.
REQ-022 Handshake: transfer occurs when cfg_valid && cfg_ready; cfg_valid without cfg_ready SHALL be held by the sender.
REQ-023 In IDLE, an accepted cfg_div SHALL load active_div directly on that edge; cfg_ready stays 1.
REQ-024 In RUN/STOPPING, an accepted cfg_div SHALL go to a shadow register, set pending, and drive cfg_ready = 0.
REQ-025 Pending divisor SHALL be copied into active_div at the next terminal count (same edge as the toggle); pending clears and cfg_ready returns to 1 next cycle.
REQ-026 Entering IDLE with pending set SHALL apply the shadow value immediately and clear pending.
REQ-027 active_div SHALL never change mid half-period (glitch-free reconfiguration).

Reset
REQ-028 rst high SHALL asynchronously force: state IDLE, cnt 0, out_clk 0, tick 0, active_div DEF_DIV, pending 0, cfg_ready 1, busy 0.
REQ-029 Reset asserted mid-RUN SHALL abort immediately with no further toggles; after release, remain IDLE until start.

Structure
REQ-030 Shared package clk_ctrl_pkg SHALL hold the state encoding typedef, CNT_W and DEF_DIV defaults.
REQ-031 Counter/toggle datapath SHALL be sub-module clk_div_core (inputs en, clr, term; outputs out_clk, tick); FSM and config handshake remain in clk_div_ctrl.

Verification (DEF_DIV = 3, CNT_W = 4 unless stated)
REQ-032 Reset, start at cycle 0 -> busy = 1 at 1; out_clk rises at cycle 5, falls at 9, period 8; tick high exactly at each toggle.
REQ-033 In RUN, cfg_div = 1 offered mid half-period -> cfg_ready drops next cycle; old period completes; half-period = 2 cycles from next toggle; cfg_ready back to 1.
REQ-034 stop while out_clk = 1 -> STOPPING, out_clk falls at next terminal, busy = 0 next edge; stop while out_clk = 0 -> IDLE next edge, no toggle.
REQ-035 start and stop same cycle in IDLE -> stays IDLE; out_clk, busy stay 0.
REQ-036 cfg_div = 0 then start -> out_clk toggles every cycle, tick constantly 1.
REQ-037 rst asserted asynchronously mid-RUN while out_clk = 1 -> out_clk 0 and active_div 3 before next clock edge; no tick after release.
